// File: rtl/harmonic_scheduler.sv
// Shares one sine ROM port across NUM_HARM harmonic oscillators, weights the returned samples and mixes them with the fundamental.
// Optional macro HARM_PHASE_SYNC_EN adds a note_start input that re-zeroes every harmonic phase.
module harmonic_scheduler #(
  parameter int NUM_HARM   = 4,
  parameter int PHASE_W    = 20,
  parameter int ROM_ADDR_W = 10,
  parameter int SAMPLE_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PHASE_W-1:0]    step_size,
  input  logic                  generate_next_sample,
`ifdef HARM_PHASE_SYNC_EN
  input  logic                  note_start,
`endif
  input  logic [SAMPLE_W-1:0]   unharmonicked_sample,
  output logic                  rom_req,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic                  rom_valid,
  input  logic [SAMPLE_W-1:0]   rom_data,
  output logic                  new_sample_out,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  busy,
  output logic                  overrun
);

  localparam int SLOT_W = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;
  localparam int ACC_W  = SAMPLE_W + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, MIX} state_t;

  state_t                     state_reg, state_next;
  logic [SLOT_W-1:0]          slot_reg;
  logic [PHASE_W-1:0]         step_reg;
  logic [SAMPLE_W-1:0]        u_reg;
  logic signed [ACC_W-1:0]    acc_reg;
  logic [SAMPLE_W-1:0]        sample_out_reg;
  logic                       new_sample_reg;
  logic                       overrun_reg;
  logic [PHASE_W-1:0]         phase_reg [NUM_HARM];
  logic [PHASE_W-1:0]         inc [NUM_HARM];
  logic                       last_slot;
  logic                       phase_clr;
  logic [1:0]                 shift_amt;
  logic signed [ACC_W-1:0]    rom_ext, rom_shift, u_ext, mix_sum;

  // Harmonic increments; anything that would exceed one full turn folds back to the fundamental.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_HARM; gi++) begin : g_inc
      logic [PHASE_W+2:0] prod;
      assign prod    = (PHASE_W+3)'(gi + 2) * {3'b000, step_reg};
      assign inc[gi] = (prod[PHASE_W+2:PHASE_W] != 3'b000) ? step_reg : prod[PHASE_W-1:0];
    end
  endgenerate

  assign last_slot = (slot_reg == SLOT_W'(NUM_HARM - 1));

`ifdef HARM_PHASE_SYNC_EN
  logic note_pend_reg;

  // A note start seen while busy is held until the scheduler is back in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_pend_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      note_pend_reg <= 1'b0;
    end else if (note_start) begin
      note_pend_reg <= 1'b1;
    end
  end

  assign phase_clr = (state_reg == IDLE) && (note_start || note_pend_reg);
`else
  assign phase_clr = 1'b0;
`endif

  always_comb begin
    if (slot_reg == '0) begin
      shift_amt = 2'd1;
    end else if (slot_reg == SLOT_W'(1)) begin
      shift_amt = 2'd2;
    end else begin
      shift_amt = 2'd3;
    end
  end

  assign rom_ext   = {{2{rom_data[SAMPLE_W-1]}}, rom_data};
  assign rom_shift = rom_ext >>> shift_amt;
  assign u_ext     = {{2{u_reg[SAMPLE_W-1]}}, u_reg};
  assign mix_sum   = (u_ext >>> 2) + (u_ext >>> 1) + (acc_reg >>> 2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rom_req    = 1'b0;
    rom_addr   = '0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (generate_next_sample) state_next = ISSUE;
      end
      ISSUE: begin
        rom_req    = 1'b1;
        rom_addr   = phase_reg[slot_reg][PHASE_W-1 -: ROM_ADDR_W];
        state_next = WAIT;
      end
      WAIT: begin
        if (rom_valid) state_next = last_slot ? MIX : ISSUE;
      end
      MIX: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_HARM; i++) phase_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_HARM; i++) begin
        if (phase_clr) begin
          phase_reg[i] <= '0;
        end else if (state_reg == ISSUE && slot_reg == SLOT_W'(i)) begin
          phase_reg[i] <= phase_reg[i] + inc[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_reg       <= '0;
      step_reg       <= '0;
      u_reg          <= '0;
      acc_reg        <= '0;
      sample_out_reg <= '0;
      new_sample_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      new_sample_reg <= 1'b0;
      overrun_reg    <= generate_next_sample && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (generate_next_sample) begin
            step_reg <= step_size;
            u_reg    <= unharmonicked_sample;
            acc_reg  <= '0;
            slot_reg <= '0;
          end
        end
        WAIT: begin
          if (rom_valid) begin
            acc_reg <= acc_reg + rom_shift;
            if (!last_slot) slot_reg <= slot_reg + 1'b1;
          end
        end
        MIX: begin
          sample_out_reg <= mix_sum[SAMPLE_W-1:0];
          new_sample_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sample_out     = sample_out_reg;
  assign new_sample_out = new_sample_reg;
  assign overrun        = overrun_reg;

endmodule
